// File: rtl/lcd_bus_receiver.sv
// Responder for an 8080-style 8-bit LCD write bus: decodes CASET/PASET/RAMWR and emits pixels.
// Build option: define LCD_RGB444_EN to reduce pix_rgb to 4:4:4 colour levels.
module lcd_bus_receiver #(
  parameter int LCD_W       = 320,
  parameter int LCD_H       = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               lcd_db,
  input  logic                     lcd_wr,
  input  logic                     lcd_d_c,
  input  logic                     lcd_rd,
  input  logic                     lcd_reset,
  output logic                     pix_valid,
  output logic [$clog2(LCD_W)-1:0] pix_x,
  output logic [$clog2(LCD_H)-1:0] pix_y,
  output logic [15:0]              pix_rgb,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_byte,
  output logic                     prot_err
);

  localparam int XW = $clog2(LCD_W);
  localparam int YW = $clog2(LCD_H);
  localparam logic [15:0] LcdW16 = 16'(LCD_W);
  localparam logic [15:0] LcdH16 = 16'(LCD_H);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCaset = 3'd1;
  localparam logic [2:0] StPaset = 3'd2;
  localparam logic [2:0] StRamwr = 3'd3;
  localparam logic [2:0] StSkip  = 3'd4;

  // Bus bundle {panel_reset_n, rd, d_c, wr, db}; idle value keeps strobes and panel reset high.
  localparam logic [11:0] BusIdle = 12'hD00;

  logic [11:0] sync_q [SYNC_STAGES];
  logic [11:0] bus_s;
  logic        wr_prev_q, rd_prev_q;
  logic        wr_evt, rd_fall, soft_rst;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BusIdle;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      sync_q[0] <= {lcd_reset, lcd_rd, lcd_d_c, lcd_wr, lcd_db};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_prev_q <= bus_s[8];
      rd_prev_q <= bus_s[10];
    end
  end

  assign bus_s    = sync_q[SYNC_STAGES-1];
  assign wr_evt   = bus_s[8] & ~wr_prev_q;
  assign rd_fall  = ~bus_s[10] & rd_prev_q;
  assign soft_rst = reset | ~bus_s[11];

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   par_q, par_d;
  logic [XW-1:0] sc_q, sc_d, ec_q, ec_d, x_q, x_d;
  logic [YW-1:0] sp_q, sp_d, ep_q, ep_d, y_q, y_d;
  logic          hi_pend_q, hi_pend_d;
  logic [7:0]    hi_q, hi_d;
  logic          pix_valid_q, pix_valid_d, cmd_valid_q, cmd_valid_d, prot_err_q, prot_err_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic [15:0]   pix_rgb_q, pix_rgb_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic [15:0]   par_start, par_end, word;

  assign par_start = par_q[23:8];
  assign par_end   = {par_q[7:0], bus_s[7:0]};
  assign word      = {hi_q, bus_s[7:0]};

  function automatic logic [15:0] fmt_rgb(input logic [15:0] w);
`ifdef LCD_RGB444_EN
    return {4'b0, w[15:12], w[10:7], w[4:1]};
`else
    return w;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_pend_d   = hi_pend_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_rgb_d   = pix_rgb_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    prot_err_d  = rd_fall;

    if (wr_evt) begin
      if (!bus_s[9]) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = bus_s[7:0];
        hi_pend_d   = 1'b0;
        cnt_d       = 2'd0;
        // Window commands only leave their state after the 4th byte, so any command here
        // interrupts them.
        if (state_q == StCaset || state_q == StPaset) prot_err_d = 1'b1;
        case (bus_s[7:0])
          8'h2A:   state_d = StCaset;
          8'h2B:   state_d = StPaset;
          8'h2C: begin
            state_d = StRamwr;
            x_d     = sc_q;
            y_d     = sp_q;
          end
          default: state_d = StSkip;
        endcase
      end else begin
        case (state_q)
          StIdle: prot_err_d = 1'b1;
          StCaset, StPaset: begin
            if (cnt_q == 2'd3) begin
              state_d = StIdle;
              cnt_d   = 2'd0;
              if (state_q == StCaset) begin
                if (par_start <= par_end && par_end < LcdW16) begin
                  sc_d = par_start[XW-1:0];
                  ec_d = par_end[XW-1:0];
                end else begin
                  prot_err_d = 1'b1;
                end
              end else begin
                if (par_start <= par_end && par_end < LcdH16) begin
                  sp_d = par_start[YW-1:0];
                  ep_d = par_end[YW-1:0];
                end else begin
                  prot_err_d = 1'b1;
                end
              end
            end else begin
              par_d = {par_q[15:0], bus_s[7:0]};
              cnt_d = cnt_q + 2'd1;
            end
          end
          StRamwr: begin
            if (!hi_pend_q) begin
              hi_d      = bus_s[7:0];
              hi_pend_d = 1'b1;
            end else begin
              hi_pend_d   = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              pix_rgb_d   = fmt_rgb(word);
              if (x_q == ec_q) begin
                x_d = sc_q;
                y_d = (y_q == ep_q) ? sp_q : y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      par_q       <= '0;
      sc_q        <= '0;
      ec_q        <= XW'(LCD_W - 1);
      sp_q        <= '0;
      ep_q        <= YW'(LCD_H - 1);
      x_q         <= '0;
      y_q         <= '0;
      hi_pend_q   <= 1'b0;
      hi_q        <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_pend_q   <= hi_pend_d;
      hi_q        <= hi_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_rgb_q   <= pix_rgb_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      prot_err_q  <= prot_err_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_rgb   = pix_rgb_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign prot_err  = prot_err_q;

endmodule
